// File: rtl/dec_onehot_scan_if.sv
// Select/scan handshake bundle for dec_onehot_scan.
// Master drives control, slave returns the registered line drive.
interface dec_onehot_scan_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic               En;
  logic               Mode;
  logic [SEL_W-1:0]   Data_in;
  logic [DWELL_W-1:0] Dwell;
  logic [OUT_W-1:0]   Data_out;
  logic [SEL_W-1:0]   Index_out;
  logic               Wrap;
  logic               Active;

  modport master (
    output En, Mode, Data_in, Dwell,
    input  Data_out, Index_out, Wrap, Active
  );

  modport slave (
    input  En, Mode, Data_in, Dwell,
    output Data_out, Index_out, Wrap, Active
  );
endinterface

// File: rtl/dec_onehot_scan.sv
// Registered binary-to-one-hot decoder with auto-scan mode.
// Scan walks one line at a time, holding each for Dwell+1 cycles.
module dec_onehot_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input logic             Clk,
  input logic             Rst_n,
  dec_onehot_scan_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   idx_inc;
  logic [DWELL_W-1:0] cnt;
  logic [OUT_W-1:0]   data_out;
  logic               wrap;
  logic               active;
  logic               dwell_done;

  function automatic logic [OUT_W-1:0] dec(
    input logic [SEL_W-1:0] s
  );
    logic [OUT_W-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  always_comb begin
    nxt = IDLE;
    if (!bus.En)
      nxt = IDLE;
    else if (!bus.Mode)
      nxt = DIRECT;
    else
      nxt = SCAN;
  end

  assign idx_inc    = idx + 1'b1;
  assign dwell_done = (cnt >= bus.Dwell);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      data_out <= '0;
      wrap     <= 1'b0;
      active   <= 1'b0;
    end else begin
      state  <= nxt;
      active <= (nxt != IDLE);
      wrap   <= 1'b0;
      case (nxt)
        IDLE: begin
          data_out <= '0;
        end
        DIRECT: begin
          idx      <= bus.Data_in;
          cnt      <= '0;
          data_out <= dec(bus.Data_in);
        end
        SCAN: begin
          if (state == DIRECT) begin
            idx      <= '0;
            cnt      <= '0;
            data_out <= dec('0);
          end else if (state == IDLE) begin
            // resume: keep the line, count this cycle toward its dwell
            data_out <= dec(idx);
            if (!dwell_done)
              cnt <= cnt + 1'b1;
          end else if (dwell_done) begin
            idx      <= idx_inc;
            cnt      <= '0;
            data_out <= dec(idx_inc);
            wrap     <= &idx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          data_out <= '0;
        end
      endcase
    end
  end

  assign bus.Data_out  = data_out;
  assign bus.Index_out = idx;
  assign bus.Wrap      = wrap;
  assign bus.Active    = active;
endmodule

// File: tb/tb_dec_onehot_scan.sv
// Scoreboard bench for dec_onehot_scan: directed phases plus random
// traffic, checked against a line/dwell reference model.
module tb_dec_onehot_scan;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;
  localparam int LINES   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dec_onehot_scan_if #(
    .SEL_W  (SEL_W),
    .DWELL_W(DWELL_W)
  ) bus ();

  dec_onehot_scan #(
    .SEL_W  (SEL_W),
    .DWELL_W(DWELL_W)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic [2:0] i;
    logic       w;
    logic       a;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference: what we are doing (0 off,1 direct,2 scan),
  // which line is selected, how long it has been shown, line lit (-1 none)
  int r_what = 0;
  int r_line = 0;
  int r_age  = 0;
  int r_lit  = -1;
  int r_wrap = 0;
  int r_on   = 0;

  task automatic ref_edge(input int r, input int e, input int m,
                          input int din, input int dw);
    int want;
    if (r == 0) begin
      r_what = 0; r_line = 0; r_age = 0;
      r_lit = -1; r_wrap = 0; r_on = 0;
      return;
    end
    want   = (e == 0) ? 0 : ((m == 0) ? 1 : 2);
    r_wrap = 0;
    if (want == 0) begin
      r_lit = -1;
    end else if (want == 1) begin
      r_line = din; r_age = 0; r_lit = din;
    end else if (r_what == 1) begin
      r_line = 0; r_age = 0; r_lit = 0;
    end else if (r_what == 0) begin
      r_lit = r_line;
      if (r_age < dw) r_age = r_age + 1;
    end else if (r_age >= dw) begin
      r_wrap = (r_line == LINES - 1) ? 1 : 0;
      r_line = (r_line + 1) % LINES;
      r_age  = 0;
      r_lit  = r_line;
    end else begin
      r_age = r_age + 1;
    end
    r_what = want;
    r_on   = (want != 0) ? 1 : 0;
  endtask

  task automatic step(input logic r, input logic e, input logic m,
                      input int din, input int dw);
    exp_t x;
    @(negedge clk);
    rst_n       = r;
    bus.En      = e;
    bus.Mode    = m;
    bus.Data_in = din[2:0];
    bus.Dwell   = dw[7:0];
    @(posedge clk);
    ref_edge(int'(r), int'(e), int'(m), din, dw);
    x.d = (r_lit < 0) ? 8'h00 : (8'h01 << r_lit);
    x.i = r_line[2:0];
    x.w = r_wrap[0];
    x.a = r_on[0];
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (bus.Data_out !== x.d || bus.Index_out !== x.i ||
            bus.Wrap !== x.w || bus.Active !== x.a) begin
          bad++;
          $display("FAIL outputs t=%0t got d=%h i=%0d w=%b a=%b exp d=%h i=%0d w=%b a=%b",
                   $time, bus.Data_out, bus.Index_out, bus.Wrap,
                   bus.Active, x.d, x.i, x.w, x.a);
        end
        total++;
        if ($countones(bus.Data_out) > 1) begin
          bad++;
          $display("FAIL onehot t=%0t got d=%h exp at most one bit",
                   $time, bus.Data_out);
        end
      end
    end
  end

  initial begin : stim
    bus.En = 1'b1; bus.Mode = 1'b1;
    bus.Data_in = '0; bus.Dwell = '0;
    repeat (2) step(1'b0, 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, i, 0);
    repeat (26) step(1'b1, 1'b1, 1'b1, 0, 2);
    step(1'b1, 1'b1, 1'b0, 4, 3);
    repeat (22) step(1'b1, 1'b1, 1'b1, 0, 3);
    repeat (4) step(1'b1, 1'b0, 1'b1, 0, 3);
    repeat (8) step(1'b1, 1'b1, 1'b1, 0, 3);
    repeat (20) step(1'b1, 1'b1, 1'b1, 0, 0);
    step(1'b1, 1'b1, 1'b0, 6, 200);
    repeat (51) step(1'b1, 1'b1, 1'b1, 0, 200);
    repeat (8) step(1'b1, 1'b1, 1'b1, 0, 1);
    repeat (5) step(1'b1, 1'b1, 1'b1, 0, 1);
    step(1'b1, 1'b1, 1'b0, 3, 1);
    repeat (4) step(1'b1, 1'b1, 1'b1, 3, 1);
    repeat (2) step(1'b0, 1'b1, 1'b1, 0, 1);
    repeat (6) step(1'b1, 1'b1, 1'b1, 0, 1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dec_onehot_scan.md
# dec_onehot_scan

Parametrised registered binary-to-one-hot decoder with an auto-scan mode, the successor to the team's fixed 3-to-8 combinational decoder. In direct mode it registers the one-hot decode of a SEL_W-bit select. In scan mode it walks the one-hot output across all 2^SEL_W lines with a programmable dwell per line. Typical uses are display digit or row multiplexing, chip-select fan-out, and keypad column drive.

## Interface
- SEL_W, 3: select width; output width OUT_W = 2^SEL_W (derived, not overridable)
- DWELL_W, 8: width of dwell counter and Dwell input
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous, active-low reset, sampled on Clk rising edge
- En  input  1  enable; 0 blanks output and pauses
- Mode  input  1  0 = direct decode, 1 = auto-scan
- Data_in  input  SEL_W  select value for direct mode
- Dwell  input  DWELL_W  extra cycles each line is held in scan (line held Dwell+1 cycles)
- Data_out  output  OUT_W  registered one-hot output, or all zeros when blanked
- Index_out  output  SEL_W  registered index currently driven
- Wrap  output  1  one-cycle pulse when scan index goes OUT_W-1 -> 0
- Active  output  1  1 when state is not IDLE

## Operation
- Internal regs: state {IDLE, DIRECT, SCAN}, idx[SEL_W-1:0], cnt[DWELL_W-1:0].
- Reset (Rst_n=0 at edge, overrides all): state=IDLE, Data_out=0, Index_out=0, idx=0, cnt=0, Wrap=0, Active=0.
- Next state, evaluated each edge:
  - En=0 -> IDLE from any state.
  - En=1, Mode=0 -> DIRECT.
  - En=1, Mode=1 -> SCAN.
- IDLE: Data_out=0. idx and cnt hold.
- DIRECT, every cycle:
  - idx <= Data_in; Data_out <= 1<<Data_in.
  - cnt <= 0.
  - Data_in is always in range, so no default case is needed; the decode is exactly one-hot.
- SCAN, entered from DIRECT: restart. idx <= 0, cnt <= 0, Data_out <= 1.
- SCAN, entered from IDLE: resume. Data_out <= 1<<idx using the held idx and cnt. cnt then advances normally from that edge.
- SCAN, continuing:
  - If cnt >= Dwell: idx <= idx+1 (modulo OUT_W), cnt <= 0, Data_out <= 1<<(idx+1).
  - Otherwise: cnt <= cnt+1 and Data_out holds.
- Dwell is sampled live. Lowering Dwell below the current cnt forces an advance on the next edge. Dwell=0 advances every cycle.
- Wrap <= 1 only on the SCAN advance edge where idx goes OUT_W-1 -> 0; otherwise 0. A restart into SCAN from DIRECT does not pulse Wrap.
- Index_out always equals the registered idx. Active <= (next state != IDLE).
- Data_out is always one-hot or zero; it is never multi-hot.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- Direct latency: Data_in sampled at edge N appears on Data_out after edge N.
- Scan period: one full sweep is OUT_W*(Dwell+1) cycles. Wrap pulses once per sweep.
- Mode change:
  - Takes effect at the first edge where the new Mode is sampled.
  - DIRECT->SCAN shows line 0 after that edge.
  - SCAN->DIRECT shows decode(Data_in) after that edge.
- En deassert: Data_out=0 after the next edge. Re-assert with Mode=1 resumes the same line; the remaining dwell is preserved because cnt holds.
- Reset mid-scan: all outputs are cleared after the reset edge. The first scan after reset starts at line 0.
- Rst_n=0 together with En=1 at the same edge: reset wins.

## Test plan
- Reset: hold Rst_n=0 for 2 cycles with En=1, Mode=1 -> Data_out=0, Index_out=0, Wrap=0, Active=0 after each edge.
- Direct sweep (SEL_W=3): En=1, Mode=0, Data_in = 0..7, one value per cycle.
  - Data_out = 8'h01, 02, 04 … 80, each one cycle after its Data_in.
  - Index_out tracks Data_in.
  - Exactly one bit is set on every cycle.
- Scan, Dwell=2: En=1, Mode=1 after DIRECT.
  - Each line is held 3 cycles: 01,01,01,02,02,02 … 80,80,80, then 01.
  - Wrap is high exactly on the cycle Data_out returns to 8'h01, and the sweep length is 24 cycles.
- Pause/resume: in SCAN with Dwell=3, drop En at the 2nd cycle of line 5 (8'h20) for 4 cycles.
  - Data_out=0 and Active=0 during the pause.
  - After re-assert, 8'h20 persists 2 more cycles, then 8'h40.
- Dwell=0 and a live Dwell change:
  - Dwell=0 -> a new line every cycle, Wrap every 8 cycles.
  - Set Dwell 200 -> 1 while cnt=50 -> advance on the next edge, then 2-cycle lines.
- Mode switch: Mode 1->0 mid-sweep with Data_in=3 -> 8'h08 after the next edge. Switch back to 1 -> 8'h01 (restart) with no Wrap pulse.
